// File: rtl/bram_pkg.sv
// bram_pkg: shared constants and FSM encoding for the BRAM port-B arbiter
package bram_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int IO_HI = 9;
  localparam int IO_LO = 8;
  localparam logic [1:0] IO_REGION = 2'b11;
  typedef enum logic [1:0] {IDLE = 2'd0, VGA = 2'd1, CPU = 2'd2, FORCE = 2'd3} state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear and async reset
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  // clear wins over increment; the count sticks at all-ones
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/bram_portb_arbiter.sv
// bram_portb_arbiter: fixed-priority BRAM port-B share with starvation guard and I/O write filter
module bram_portb_arbiter
  import bram_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MAX_WAIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r0_req,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [WIDTH-1:0]      r0_rdata,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [WIDTH-1:0]      r1_wdata,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [WIDTH-1:0]      r1_rdata,
  output logic                  r1_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_data,
  output logic                  mem_we,
  input  logic [WIDTH-1:0]      mem_q,
  output logic [7:0]            force_cnt
);
  state_t state, next_state;
  logic [7:0] wait_cnt;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic force_gnt, io, last_we, last_io, r1_last;

  assign force_gnt = r1_req && wait_cnt >= 8'(MAX_WAIT);
  assign io = r1_addr[IO_HI:IO_LO] == IO_REGION;
  assign mem_data = r1_wdata;
  assign r1_last = state == CPU || state == FORCE;
  assign r0_rvalid = state == VGA;
  assign r1_rvalid = r1_last && !last_we;
  assign r1_err = r1_last && last_we && last_io;

  // winner selection; state register doubles as the record of who was granted
  always_comb begin
    next_state = IDLE;
    next_state = force_gnt ? FORCE : r0_req ? VGA : r1_req ? CPU : IDLE;
    r0_gnt = !reset && next_state == VGA;
    r1_gnt = !reset && (next_state == CPU || next_state == FORCE);
    mem_addr = r0_gnt ? r0_addr : r1_gnt ? r1_addr : last_addr;
    mem_we = r1_gnt && r1_we && !io;
  end

  // state, held address and read-return capture of the BRAM output
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      last_addr <= '0;
      last_we <= 1'b0;
      last_io <= 1'b0;
      r0_rdata <= '0;
      r1_rdata <= '0;
    end else begin
      state <= next_state;
      last_addr <= mem_addr;
      last_we <= r1_we;
      last_io <= io;
      if (r0_gnt) r0_rdata <= mem_q;
      if (r1_gnt && !r1_we) r1_rdata <= mem_q;
    end

  sat_counter #(.W(8)) u_wait (
    .clk(clk), .reset(reset), .inc(r1_req && !r1_gnt), .clr(!r1_req || r1_gnt), .cnt(wait_cnt)
  );

  sat_counter #(.W(8)) u_force (
    .clk(clk), .reset(reset), .inc(force_gnt && r0_req), .clr(1'b0), .cnt(force_cnt)
  );
endmodule

// File: tb/tb_bram_portb_arbiter.sv
// tb_bram_portb_arbiter: directed checks of arbitration, latency, I/O filter and saturation
module tb_bram_portb_arbiter;
  logic clk = 0, reset = 1;
  logic r0_req = 0, r1_req = 0, r1_we = 0;
  logic [9:0] r0_addr = 0, r1_addr = 0;
  logic [15:0] r1_wdata = 0;
  logic r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, r1_err, mem_we;
  logic [15:0] r0_rdata, r1_rdata, mem_data, mem_q;
  logic [9:0] mem_addr;
  logic [7:0] force_cnt;
  logic g0_1, v0_1, g1_1, v1_1, e_1, we_1;
  logic [15:0] d0_1, d1_1, md_1, q_1;
  logic [9:0] ma_1;
  logic [7:0] fc_1;
  logic [15:0] mem0 [0:1023];
  logic [15:0] mem1 [0:1023];
  int errors = 0, checks = 0, bad = 0;

  always #5 clk = ~clk;

  bram_portb_arbiter #(.MAX_WAIT(8)) dut (
    .clk(clk), .reset(reset), .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(r0_gnt),
    .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r1_req(r1_req), .r1_we(r1_we),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
    .r1_rdata(r1_rdata), .r1_err(r1_err), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .mem_q(mem_q), .force_cnt(force_cnt)
  );

  bram_portb_arbiter #(.MAX_WAIT(1)) dut1 (
    .clk(clk), .reset(reset), .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(g0_1),
    .r0_rvalid(v0_1), .r0_rdata(d0_1), .r1_req(r1_req), .r1_we(r1_we),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_gnt(g1_1), .r1_rvalid(v1_1),
    .r1_rdata(d1_1), .r1_err(e_1), .mem_addr(ma_1), .mem_data(md_1),
    .mem_we(we_1), .mem_q(q_1), .force_cnt(fc_1)
  );

  always @(negedge clk)
    if (reset) for (int i = 0; i < 1024; i++) mem0[i] <= 16'h0;
    else begin
      if (mem_we) mem0[mem_addr] <= mem_data;
      mem_q <= mem0[mem_addr];
    end

  always @(negedge clk)
    if (reset) for (int i = 0; i < 1024; i++) mem1[i] <= 16'h0;
    else begin
      if (we_1) mem1[ma_1] <= md_1;
      q_1 <= mem1[ma_1];
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick;
    tick;
    chk("rst_r0_gnt", 32'(r0_gnt), 0);
    chk("rst_r1_gnt", 32'(r1_gnt), 0);
    chk("rst_rvalid", 32'({r0_rvalid, r1_rvalid, r1_err}), 0);
    chk("rst_force_cnt", 32'(force_cnt), 0);
    chk("rst_rdata", 32'({r0_rdata, r1_rdata}), 0);
    reset = 0;
    tick;
    r1_req = 1; r1_we = 1; r1_addr = 10'h020; r1_wdata = 16'hBEEF;
    #1;
    chk("wr_gnt", 32'(r1_gnt), 1);
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h020);
    tick;
    r1_we = 0;
    #1;
    chk("rd_gnt", 32'(r1_gnt), 1);
    chk("rd_mem_we", 32'(mem_we), 0);
    chk("wr_no_rvalid", 32'(r1_rvalid), 0);
    tick;
    r1_req = 0;
    #1;
    chk("rd_rvalid", 32'(r1_rvalid), 1);
    chk("rd_rdata", 32'(r1_rdata), 32'hBEEF);
    tick;
    chk("rd_rvalid_drop", 32'(r1_rvalid), 0);
    for (int i = 0; i < 4; i++) begin
      r1_req = 1; r1_we = 1; r1_addr = 10'(i); r1_wdata = 16'(16'h1111 * (i + 1));
      tick;
    end
    r1_req = 0; r1_we = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      r0_req = i < 4; r0_addr = 10'(i);
      #1;
      if (i < 4) chk("b2b_gnt", 32'(r0_gnt), 1);
      if (i > 0) begin
        chk("b2b_rvalid", 32'(r0_rvalid), 1);
        chk("b2b_rdata", 32'(r0_rdata), 32'(16'h1111 * i));
      end
    end
    tick;
    chk("b2b_rvalid_end", 32'(r0_rvalid), 0);
    r0_req = 1; r0_addr = 10'h005; r1_req = 1; r1_we = 0; r1_addr = 10'h010;
    for (int k = 1; k <= 10; k++) begin
      #1;
      chk("prio_r0_gnt", 32'(r0_gnt), 32'(k != 9));
      chk("prio_r1_gnt", 32'(r1_gnt), 32'(k == 9));
      if (k == 10) begin
        chk("prio_state_force", 32'(dut.state), 3);
        chk("prio_r1_rvalid", 32'(r1_rvalid), 1);
      end
      tick;
    end
    chk("prio_force_cnt", 32'(force_cnt), 1);
    r0_req = 0; r1_req = 1; r1_we = 0; r1_addr = 10'h010;
    #1;
    chk("mid_gnt", 32'(r1_gnt), 1);
    reset = 1;
    #1;
    chk("mid_rst_gnt", 32'(r1_gnt), 0);
    chk("mid_rst_force_cnt", 32'(force_cnt), 0);
    tick;
    reset = 0; r1_req = 0;
    #1;
    chk("mid_rvalid", 32'(r1_rvalid), 0);
    chk("mid_state", 32'(dut.state), 0);
    chk("mid_force_cnt", 32'(force_cnt), 0);
    tick;
    r1_req = 1; r1_we = 1; r1_addr = 10'h300; r1_wdata = 16'h5A5A;
    #1;
    chk("io_gnt", 32'(r1_gnt), 1);
    chk("io_mem_we", 32'(mem_we), 0);
    chk("io_err_early", 32'(r1_err), 0);
    tick;
    r1_we = 0; r1_addr = 10'h301;
    #1;
    chk("io_err", 32'(r1_err), 1);
    chk("io_wr_rvalid", 32'(r1_rvalid), 0);
    chk("io_rd_gnt", 32'(r1_gnt), 1);
    tick;
    r1_req = 0;
    #1;
    chk("io_err_pulse", 32'(r1_err), 0);
    chk("io_rd_rvalid", 32'(r1_rvalid), 1);
    chk("io_rd_rdata", 32'(r1_rdata), 0);
    chk("io_mem_untouched", 32'(mem0[10'h300]), 0);
    reset = 1;
    tick;
    reset = 0; r0_req = 1; r0_addr = 10'h000; r1_req = 1; r1_we = 0; r1_addr = 10'h040;
    for (int k = 1; k <= 600; k++) begin
      #1;
      if (g0_1 !== 1'(k % 2) || g1_1 !== 1'((k + 1) % 2)) bad++;
      tick;
    end
    r0_req = 0; r1_req = 0;
    chk("sat_alternate", 32'(bad), 0);
    chk("sat_force_cnt", 32'(fc_1), 255);
    chk("sat_force_cnt_mw8", 32'(force_cnt), 66);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
